lab61soc_led_out: RTL and testbench
===================================

LAB61SOC_LED_OUT -- requirements
Module: lab61soc_led_out

Interface
REQ-001 Parameter WIDTH, default 8: width of out_port and of every bit-mask register.
REQ-002 Parameter RESET_VALUE, default 0: value loaded into the data register on reset.
REQ-003 clk  input  1: single system clock; all state updates on its rising edge.
REQ-004 reset_n  input  1: asynchronous, active-low reset.
REQ-005 address  input  3: Avalon-MM slave word address.
REQ-006 chipselect  input  1: slave select; qualifies writes.
REQ-007 write_n  input  1: active-low write strobe.
REQ-008 writedata  input  32: write data.
REQ-009 readdata  output  32: registered read data.
REQ-010 out_port  output  WIDTH: registered parallel output to board LEDs.

Function
REQ-011 A write SHALL occur on a rising edge with chipselect=1 and write_n=0; no other condition alters any register.
REQ-012 The register map SHALL be: 0 DATA (R/W), 2 PULSE_LEN (R/W, 16 bits), 3 PULSE (W: trigger; R: status), 4 OUTSET (W), 5 OUTCLEAR (W); addresses 1, 6, 7 SHALL read 0 and ignore writes.
REQ-013 A DATA write SHALL load data_reg <= writedata[WIDTH-1:0].
REQ-014 An OUTSET write SHALL perform data_reg <= data_reg | writedata[WIDTH-1:0].
REQ-015 An OUTCLEAR write SHALL perform data_reg <= data_reg & ~writedata[WIDTH-1:0].
REQ-016 A PULSE_LEN write SHALL load pulse_len <= writedata[15:0].
REQ-017 The pulse engine SHALL have two states, IDLE and PULSE.
REQ-018 A PULSE write with pulse_len != 0 SHALL load pulse_mask <= writedata[WIDTH-1:0], load count <= pulse_len, and enter PULSE, from either state (a write during PULSE restarts the pulse).
REQ-019 A PULSE write with pulse_len == 0 SHALL force IDLE and clear pulse_mask.
REQ-020 In PULSE without a PULSE write, count SHALL decrement by 1 per cycle; on the edge where count==1, the engine SHALL enter IDLE, clear pulse_mask and set count to 0.
REQ-021 A PULSE write on the edge where count==1 SHALL take priority over expiry.
REQ-022 out_port SHALL be registered: out_port <= next_data_reg | next_pulse_mask, so a register write becomes visible on out_port at the same edge that updates the register.
REQ-023 A pulse with pulse_len=N SHALL hold the pulse_mask bits high on out_port for exactly N cycles.
REQ-024 readdata SHALL be registered every clock (independent of chipselect) from address sampled at that edge, giving one-cycle read latency.
REQ-025 Read values: addr 0 -> {zero-extend, data_reg}; addr 2 -> {16'b0, pulse_len}; addr 3 -> {bit31 = (state==PULSE), bits15:0 = count, others 0}; addrs 4 and 5 -> {zero-extend, data_reg}; all other addresses -> 0.
REQ-026 Unused high bits of writedata SHALL be ignored.

Reset
REQ-027 On reset_n=0, asynchronously: data_reg=RESET_VALUE, pulse_len=0, pulse_mask=0, count=0, state=IDLE, out_port=RESET_VALUE, readdata=0.
REQ-028 Reset asserted during PULSE SHALL abort the pulse immediately; after release the engine stays IDLE until the next PULSE write.
REQ-029 The first write SHALL be accepted on the first rising edge after reset_n deasserts.

Verification
REQ-030 Write DATA=0x5A, then read addr 0 -> out_port=0x5A at the write edge; readdata=0x0000005A one cycle after the address is presented.
REQ-031 DATA=0x0F, OUTSET 0xF0, OUTCLEAR 0x03 -> out_port 0x0F -> 0xFF -> 0xFC on successive write edges.
REQ-032 DATA=0x00, PULSE_LEN=3, PULSE write 0x81 -> out_port=0x81 for exactly 3 cycles, then 0x00; a read of addr 3 in the first pulse cycle returns 0x80000003.
REQ-033 PULSE_LEN=4, PULSE 0x01, then PULSE 0x02 on the edge where count==1 -> out_port=0x02 for 4 further cycles; bit 0 drops at the restart edge.
REQ-034 PULSE_LEN=10, PULSE 0xFF, then assert reset_n=0 mid-pulse -> out_port=0x00 and readdata=0 immediately; addr 3 reads 0x00000000 after release.
REQ-035 Write 0xFFFFFFFF to addr 1, 6 and 7, and issue a write with chipselect=0 -> all registers unchanged; those addresses read 0.

Source files
------------

// File: rtl/lab61soc_led_out.sv
// ============================================================================
// lab61soc_led_out : Avalon-MM LED output port with set/clear and timed pulses
// Revision: 1.0
// ============================================================================
`default_nettype none

module lab61soc_led_out #(
  parameter int WIDTH       = 8,
  parameter int RESET_VALUE = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  localparam logic [2:0] c_addr_data      = 3'd0;
  localparam logic [2:0] c_addr_pulse_len = 3'd2;
  localparam logic [2:0] c_addr_pulse     = 3'd3;
  localparam logic [2:0] c_addr_outset    = 3'd4;
  localparam logic [2:0] c_addr_outclear  = 3'd5;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_PULSE = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] r_pulse_mask;
  logic [15:0]      r_pulse_len;
  logic [15:0]      r_count;

  logic             w_wr;
  logic [WIDTH-1:0] w_wdata;
  logic [WIDTH-1:0] w_data_next;
  logic [15:0]      w_pulse_len_next;
  state_t           w_state_next;
  logic [WIDTH-1:0] w_mask_next;
  logic [15:0]      w_count_next;
  logic [31:0]      w_data_ext;
  logic [31:0]      w_rd_next;
  logic             w_unused_wdata;

  assign w_wr           = chipselect & ~write_n;
  assign w_wdata        = writedata[WIDTH-1:0];
  assign w_unused_wdata = &{1'b0, writedata};

  always_comb begin
    w_data_next      = r_data;
    w_pulse_len_next = r_pulse_len;
    if (w_wr) begin
      case (address)
        c_addr_data:      w_data_next      = w_wdata;
        c_addr_outset:    w_data_next      = r_data | w_wdata;
        c_addr_outclear:  w_data_next      = r_data & ~w_wdata;
        c_addr_pulse_len: w_pulse_len_next = writedata[15:0];
        default: ;
      endcase
    end
  end

  // A trigger write always wins over the expiry of a running pulse.
  always_comb begin
    w_state_next = r_state;
    w_mask_next  = r_pulse_mask;
    w_count_next = r_count;
    if (w_wr && address == c_addr_pulse) begin
      if (r_pulse_len != 16'd0) begin
        w_state_next = ST_PULSE;
        w_mask_next  = w_wdata;
        w_count_next = r_pulse_len;
      end else begin
        w_state_next = ST_IDLE;
        w_mask_next  = '0;
        w_count_next = 16'd0;
      end
    end else if (r_state == ST_PULSE) begin
      if (r_count == 16'd1) begin
        w_state_next = ST_IDLE;
        w_mask_next  = '0;
        w_count_next = 16'd0;
      end else begin
        w_count_next = r_count - 16'd1;
      end
    end
  end

  always_comb begin
    w_data_ext               = '0;
    w_data_ext[WIDTH-1:0]    = r_data;
    w_rd_next                = '0;
    case (address)
      c_addr_data, c_addr_outset, c_addr_outclear: w_rd_next = w_data_ext;
      c_addr_pulse_len: w_rd_next = {16'd0, r_pulse_len};
      c_addr_pulse:     w_rd_next = {(r_state == ST_PULSE), 15'd0, r_count};
      default:          w_rd_next = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_data       <= WIDTH'(RESET_VALUE);
      r_pulse_mask <= '0;
      r_pulse_len  <= 16'd0;
      r_count      <= 16'd0;
      out_port     <= WIDTH'(RESET_VALUE);
      readdata     <= 32'd0;
    end else begin
      r_state      <= w_state_next;
      r_data       <= w_data_next;
      r_pulse_mask <= w_mask_next;
      r_pulse_len  <= w_pulse_len_next;
      r_count      <= w_count_next;
      out_port     <= w_data_next | w_mask_next;
      readdata     <= w_rd_next;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lab61soc_led_out.sv
// ============================================================================
// tb_lab61soc_led_out : table-driven bench for lab61soc_led_out
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_lab61soc_led_out;

  logic        clk;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  out_port;

  int n_cmp;
  int n_bad;

  lab61soc_led_out #(.WIDTH(8), .RESET_VALUE(0)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One record = one clock: inputs driven before the edge, outputs checked after it.
  // readdata reflects this record's address with the register values before the edge.
  typedef struct {
    logic [2:0]  addr;
    logic        cs;
    logic        wn;
    logic [31:0] wd;
    logic [7:0]  exp_out;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] a, input logic cs, input logic wn, input logic [31:0] wd);
    address    = a;
    chipselect = cs;
    write_n    = wn;
    writedata  = wd;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] wd, input logic [7:0] eo, input logic [31:0] er);
    vecs.push_back(vec_t'{a, 1'b1, 1'b0, wd, eo, er});
  endtask

  task automatic rd(input logic [2:0] a, input logic [7:0] eo, input logic [31:0] er);
    vecs.push_back(vec_t'{a, 1'b0, 1'b1, 32'h0, eo, er});
  endtask

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    reset_n = 1'b0;
    drive(3'd0, 1'b0, 1'b1, 32'h0);

    // DATA write and readback
    wr(3'd0, 32'h5A, 8'h5A, 32'h0);
    rd(3'd0, 8'h5A, 32'h5A);
    // DATA / OUTSET / OUTCLEAR
    wr(3'd0, 32'h0F, 8'h0F, 32'h5A);
    wr(3'd4, 32'hF0, 8'hFF, 32'h0F);
    wr(3'd5, 32'h03, 8'hFC, 32'hFF);
    rd(3'd5, 8'hFC, 32'hFC);
    // unmapped addresses and unqualified writes
    wr(3'd1, 32'hFFFFFFFF, 8'hFC, 32'h0);
    wr(3'd6, 32'hFFFFFFFF, 8'hFC, 32'h0);
    wr(3'd7, 32'hFFFFFFFF, 8'hFC, 32'h0);
    vecs.push_back(vec_t'{3'd0, 1'b0, 1'b0, 32'h0, 8'hFC, 32'hFC});
    vecs.push_back(vec_t'{3'd0, 1'b1, 1'b1, 32'h0, 8'hFC, 32'hFC});
    rd(3'd2, 8'hFC, 32'h0);
    // trigger with zero length does nothing visible
    wr(3'd3, 32'hFF, 8'hFC, 32'h0);
    // pulse of length 3, high bits of writedata ignored
    wr(3'd2, 32'hABCD0003, 8'hFC, 32'h0);
    rd(3'd2, 8'hFC, 32'h3);
    wr(3'd0, 32'h00, 8'h00, 32'hFC);
    wr(3'd3, 32'h81, 8'h81, 32'h0);
    rd(3'd3, 8'h81, 32'h80000003);
    rd(3'd3, 8'h81, 32'h80000002);
    rd(3'd3, 8'h00, 32'h80000001);
    rd(3'd3, 8'h00, 32'h0);
    // restart on the count==1 edge
    wr(3'd2, 32'h4, 8'h00, 32'h3);
    wr(3'd3, 32'h01, 8'h01, 32'h0);
    rd(3'd3, 8'h01, 32'h80000004);
    rd(3'd3, 8'h01, 32'h80000003);
    rd(3'd3, 8'h01, 32'h80000002);
    wr(3'd3, 32'h02, 8'h02, 32'h80000001);
    rd(3'd3, 8'h02, 32'h80000004);
    rd(3'd3, 8'h02, 32'h80000003);
    rd(3'd3, 8'h02, 32'h80000002);
    rd(3'd3, 8'h00, 32'h80000001);
    rd(3'd3, 8'h00, 32'h0);
    // pulse OR'd with data, data edits during a pulse, zero-length abort
    wr(3'd0, 32'h10, 8'h10, 32'h0);
    wr(3'd3, 32'h01, 8'h11, 32'h0);
    wr(3'd5, 32'h10, 8'h01, 32'h10);
    wr(3'd2, 32'h0, 8'h01, 32'h4);
    wr(3'd3, 32'h55, 8'h00, 32'h80000002);
    rd(3'd3, 8'h00, 32'h0);

    // reset state
    #3;
    check("reset out_port", {24'h0, out_port}, 32'h0);
    check("reset readdata", readdata, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check("reset held out_port", {24'h0, out_port}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].addr, vecs[i].cs, vecs[i].wn, vecs[i].wd);
      @(posedge clk);
      #1;
      check($sformatf("v%0d out_port", i), {24'h0, out_port}, {24'h0, vecs[i].exp_out});
      check($sformatf("v%0d readdata", i), readdata, vecs[i].exp_rd);
    end

    // reset asserted mid-pulse
    @(negedge clk);
    drive(3'd2, 1'b1, 1'b0, 32'd10);
    @(negedge clk);
    drive(3'd3, 1'b1, 1'b0, 32'hFF);
    @(negedge clk);
    drive(3'd3, 1'b0, 1'b1, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("mid-pulse out_port", {24'h0, out_port}, 32'hFF);
    check("mid-pulse status", readdata, 32'h80000009);
    #2;
    reset_n = 1'b0;
    #1;
    check("async reset out_port", {24'h0, out_port}, 32'h0);
    check("async reset readdata", readdata, 32'h0);
    @(posedge clk);
    #1;
    check("reset during clk out_port", {24'h0, out_port}, 32'h0);

    // first write accepted on the first edge after release
    @(negedge clk);
    reset_n = 1'b1;
    drive(3'd0, 1'b1, 1'b0, 32'h33);
    @(posedge clk);
    #1;
    check("first write out_port", {24'h0, out_port}, 32'h33);
    check("first write readdata", readdata, 32'h0);
    @(negedge clk);
    drive(3'd3, 1'b0, 1'b1, 32'h0);
    @(posedge clk);
    #1;
    check("post-reset status", readdata, 32'h0);
    check("post-reset out_port", {24'h0, out_port}, 32'h33);
    @(negedge clk);
    drive(3'd2, 1'b0, 1'b1, 32'h0);
    @(posedge clk);
    #1;
    check("post-reset pulse_len", readdata, 32'h0);
    @(negedge clk);
    drive(3'd0, 1'b0, 1'b1, 32'h0);
    @(posedge clk);
    #1;
    check("post-reset data", readdata, 32'h33);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
